ff_bank_universal: RTL and testbench

WIDTH-bit register bank in which every bit is a universal flip-flop, acting as a D, T, JK or SR flip-flop according to a run-time mode input. This generalises the single-bit, fixed-type flip-flop conversions to a parametrised width with a selectable mode. It adds an enable, a programmable reset value, per-bit change reporting and sticky detection of the SR illegal input. It serves as the common storage primitive for counters and control registers.

---
 rtl/ff_bank_universal_pkg.sv | 12 +
 rtl/ff_bank_universal_if.sv | 28 ++
 rtl/ff_bank_universal_cell.sv | 68 ++++++
 rtl/ff_bank_universal.sv | 52 +++++
 tb/tb_ff_bank_universal.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/ff_bank_universal_pkg.sv
// Shared definitions for the universal flip-flop bank: mode encodings and mode type.
// Imported by the cell, the bank top and the bus interface.
package ff_pkg;

  typedef logic [1:0] ff_mode_t;

  localparam ff_mode_t FF_MODE_D  = 2'd0;
  localparam ff_mode_t FF_MODE_T  = 2'd1;
  localparam ff_mode_t FF_MODE_JK = 2'd2;
  localparam ff_mode_t FF_MODE_SR = 2'd3;

endpackage

// File: rtl/ff_bank_universal_if.sv
// Bus bundle for the flip-flop bank: control/data towards the bank, state and flags back.
// The master modport drives the bank; the slave modport is the bank itself.
interface ff_bank_universal_if #(
  parameter int WIDTH = 8
);
  import ff_pkg::*;

  logic             en;
  ff_mode_t         mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] chg;
  logic             sr_err;

  modport master (
    output en, mode, a, b, err_clr,
    input  q, qb, chg, sr_err
  );

  modport slave (
    input  en, mode, a, b, err_clr,
    output q, qb, chg, sr_err
  );

endinterface

// File: rtl/ff_bank_universal_cell.sv
// One universal flip-flop bit (D/T/JK/SR selected at run time) with registered
// complement, change flag and a combinational SR-illegal indication.
module ff_cell
  import ff_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_en,
  input  ff_mode_t i_mode,
  input  logic     i_a,
  input  logic     i_b,
  input  logic     i_rstVal,
  output logic     o_q,
  output logic     o_qb,
  output logic     o_chg,
  output logic     o_illegal
);

  logic r_q;
  logic r_qb;
  logic r_chg;
  logic w_qNext;

  always_comb begin
    w_qNext = r_q;
    if (i_en) begin
      unique case (i_mode)
        FF_MODE_D:  w_qNext = i_a;
        FF_MODE_T:  w_qNext = r_q ^ i_a;
        FF_MODE_JK: begin
          unique case ({i_a, i_b})
            2'b00:   w_qNext = r_q;
            2'b01:   w_qNext = 1'b0;
            2'b10:   w_qNext = 1'b1;
            default: w_qNext = ~r_q;
          endcase
        end
        default: begin
          // S=R=1 is illegal for SR; the bit simply keeps its value
          unique case ({i_a, i_b})
            2'b01:   w_qNext = 1'b0;
            2'b10:   w_qNext = 1'b1;
            default: w_qNext = r_q;
          endcase
        end
      endcase
    end
  end

  // qb is its own register loaded with the complement so it never lags q
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= i_rstVal;
      r_qb  <= ~i_rstVal;
      r_chg <= 1'b0;
    end else begin
      r_q   <= w_qNext;
      r_qb  <= ~w_qNext;
      r_chg <= i_en & (w_qNext ^ r_q);
    end
  end

  assign o_q       = r_q;
  assign o_qb      = r_qb;
  assign o_chg     = r_chg;
  assign o_illegal = i_en & (i_mode == FF_MODE_SR) & i_a & i_b;

endmodule

// File: rtl/ff_bank_universal.sv
// WIDTH-bit bank of universal flip-flops sharing one mode, plus a sticky flag
// that records any SR illegal input until explicitly cleared.
module ff_bank_universal
  import ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic                clk,
  input logic                rst,
  ff_bank_universal_if.slave bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_illegal;
  logic             r_srErr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.en),
      .i_mode    (bus.mode),
      .i_a       (bus.a[i]),
      .i_b       (bus.b[i]),
      .i_rstVal  (RESET_VAL[i]),
      .o_q       (w_q[i]),
      .o_qb      (w_qb[i]),
      .o_chg     (w_chg[i]),
      .o_illegal (w_illegal[i])
    );
  end

  // A new illegal input outranks a simultaneous clear so no event is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srErr <= 1'b0;
    end else if (|w_illegal) begin
      r_srErr <= 1'b1;
    end else if (bus.err_clr) begin
      r_srErr <= 1'b0;
    end
  end

  assign bus.q      = w_q;
  assign bus.qb     = w_qb;
  assign bus.chg    = w_chg;
  assign bus.sr_err = r_srErr;

endmodule

// File: tb/tb_ff_bank_universal.sv
// Directed and randomised checks of the universal flip-flop bank (WIDTH=8, RESET_VAL=A5)
// against hand-computed vectors and a behavioural per-bit model.
module tb_ff_bank_universal;
  import ff_pkg::*;

  localparam int         W    = 8;
  localparam logic [7:0] RVAL = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ff_bank_universal_if #(.WIDTH(W)) bus ();

  ff_bank_universal #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic applyStimulus(input logic r, input logic e, input ff_mode_t m,
                               input logic [7:0] av, input logic [7:0] bv, input logic clr);
    rst         = r;
    bus.en      = e;
    bus.mode    = m;
    bus.a       = av;
    bus.b       = bv;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, FF_MODE_D, 8'hFF, 8'h00, 1'b0);
    checks++; if (bus.q !== 8'hA5) begin failures++; $display("[TB] FAIL reset_q got=%h exp=a5", bus.q); end
    checks++; if (bus.qb !== 8'h5A) begin failures++; $display("[TB] FAIL reset_qb got=%h exp=5a", bus.qb); end
    checks++; if (bus.chg !== 8'h00) begin failures++; $display("[TB] FAIL reset_chg got=%h exp=00", bus.chg); end
    checks++; if (bus.sr_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.sr_err); end
  endtask

  task automatic test_d();
    applyStimulus(1'b0, 1'b1, FF_MODE_D, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, FF_MODE_D, 8'h3C, 8'hFF, 1'b0);
    checks++; if (bus.q !== 8'h3C) begin failures++; $display("[TB] FAIL d_q got=%h exp=3c", bus.q); end
    checks++; if (bus.qb !== 8'hC3) begin failures++; $display("[TB] FAIL d_qb got=%h exp=c3", bus.qb); end
    checks++; if (bus.chg !== 8'h3C) begin failures++; $display("[TB] FAIL d_chg got=%h exp=3c", bus.chg); end
    applyStimulus(1'b0, 1'b0, FF_MODE_D, 8'h00, 8'h00, 1'b0);
    checks++; if (bus.q !== 8'h3C) begin failures++; $display("[TB] FAIL d_hold_q got=%h exp=3c", bus.q); end
    checks++; if (bus.chg !== 8'h00) begin failures++; $display("[TB] FAIL d_hold_chg got=%h exp=00", bus.chg); end
  endtask

  task automatic test_t();
    applyStimulus(1'b0, 1'b1, FF_MODE_T, 8'hFF, 8'h00, 1'b0);
    checks++; if (bus.q !== 8'hC3) begin failures++; $display("[TB] FAIL t1_q got=%h exp=c3", bus.q); end
    checks++; if (bus.chg !== 8'hFF) begin failures++; $display("[TB] FAIL t1_chg got=%h exp=ff", bus.chg); end
    applyStimulus(1'b0, 1'b1, FF_MODE_T, 8'hFF, 8'h00, 1'b0);
    checks++; if (bus.q !== 8'h3C) begin failures++; $display("[TB] FAIL t2_q got=%h exp=3c", bus.q); end
    checks++; if (bus.chg !== 8'hFF) begin failures++; $display("[TB] FAIL t2_chg got=%h exp=ff", bus.chg); end
    applyStimulus(1'b0, 1'b1, FF_MODE_T, 8'h00, 8'h00, 1'b0);
    checks++; if (bus.q !== 8'h3C) begin failures++; $display("[TB] FAIL t0_q got=%h exp=3c", bus.q); end
    checks++; if (bus.chg !== 8'h00) begin failures++; $display("[TB] FAIL t0_chg got=%h exp=00", bus.chg); end
  endtask

  task automatic test_jk();
    applyStimulus(1'b0, 1'b1, FF_MODE_D, 8'h0F, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, FF_MODE_JK, 8'hF0, 8'h3C, 1'b0);
    checks++; if (bus.q !== 8'hF3) begin failures++; $display("[TB] FAIL jk_q got=%h exp=f3", bus.q); end
    checks++; if (bus.qb !== 8'h0C) begin failures++; $display("[TB] FAIL jk_qb got=%h exp=0c", bus.qb); end
    checks++; if (bus.chg !== 8'hFC) begin failures++; $display("[TB] FAIL jk_chg got=%h exp=fc", bus.chg); end
    checks++; if (bus.sr_err !== 1'b0) begin failures++; $display("[TB] FAIL jk_err got=%b exp=0", bus.sr_err); end
  endtask

  task automatic test_sr();
    applyStimulus(1'b0, 1'b1, FF_MODE_SR, 8'h01, 8'h81, 1'b0);
    checks++; if (bus.q !== 8'h73) begin failures++; $display("[TB] FAIL sr_q got=%h exp=73", bus.q); end
    checks++; if (bus.chg !== 8'h80) begin failures++; $display("[TB] FAIL sr_chg got=%h exp=80", bus.chg); end
    checks++; if (bus.sr_err !== 1'b1) begin failures++; $display("[TB] FAIL sr_err_set got=%b exp=1", bus.sr_err); end
    applyStimulus(1'b0, 1'b1, FF_MODE_SR, 8'h01, 8'h01, 1'b1);
    checks++; if (bus.sr_err !== 1'b1) begin failures++; $display("[TB] FAIL sr_set_wins got=%b exp=1", bus.sr_err); end
    checks++; if (bus.q !== 8'h73) begin failures++; $display("[TB] FAIL sr_illegal_q got=%h exp=73", bus.q); end
    applyStimulus(1'b0, 1'b1, FF_MODE_SR, 8'h00, 8'h00, 1'b1);
    checks++; if (bus.sr_err !== 1'b0) begin failures++; $display("[TB] FAIL sr_clear got=%b exp=0", bus.sr_err); end
    checks++; if (bus.q !== 8'h73) begin failures++; $display("[TB] FAIL sr_hold_q got=%h exp=73", bus.q); end
    // illegal pattern with en=0 must not set the flag
    applyStimulus(1'b0, 1'b0, FF_MODE_SR, 8'hFF, 8'hFF, 1'b0);
    checks++; if (bus.sr_err !== 1'b0) begin failures++; $display("[TB] FAIL sr_en_gate got=%b exp=0", bus.sr_err); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 1'b1, FF_MODE_SR, 8'h10, 8'h10, 1'b0);
    applyStimulus(1'b0, 1'b1, FF_MODE_D, 8'h3C, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, FF_MODE_T, 8'hFF, 8'h00, 1'b0);
    checks++; if (bus.q !== 8'hA5) begin failures++; $display("[TB] FAIL mid_rst_q got=%h exp=a5", bus.q); end
    checks++; if (bus.qb !== 8'h5A) begin failures++; $display("[TB] FAIL mid_rst_qb got=%h exp=5a", bus.qb); end
    checks++; if (bus.chg !== 8'h00) begin failures++; $display("[TB] FAIL mid_rst_chg got=%h exp=00", bus.chg); end
    checks++; if (bus.sr_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_err got=%b exp=0", bus.sr_err); end
  endtask

  task automatic test_random();
    logic [7:0] mq   = 8'hA5;
    logic [7:0] mchg = 8'h00;
    logic       merr = 1'b0;
    logic [7:0] nq;
    logic       r, e, clr;
    ff_mode_t   m;
    logic [7:0] av, bv;
    int         nfail = 0;
    applyStimulus(1'b1, 1'b0, FF_MODE_D, 8'h00, 8'h00, 1'b0);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r   = ($urandom_range(0, 63) == 0);
      e   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      m   = ff_mode_t'($urandom_range(0, 3));
      av  = 8'($urandom);
      bv  = 8'($urandom);
      if (r) begin
        mq = RVAL; mchg = 8'h00; merr = 1'b0;
      end else if (e) begin
        for (int i = 0; i < 8; i++) begin
          case (m)
            FF_MODE_D:  nq[i] = av[i];
            FF_MODE_T:  nq[i] = av[i] ? ~mq[i] : mq[i];
            FF_MODE_JK: nq[i] = (av[i] && bv[i]) ? ~mq[i] : av[i] ? 1'b1 : bv[i] ? 1'b0 : mq[i];
            default:    nq[i] = (av[i] && !bv[i]) ? 1'b1 : (!av[i] && bv[i]) ? 1'b0 : mq[i];
          endcase
        end
        mchg = nq ^ mq;
        mq   = nq;
        if (m == FF_MODE_SR && (av & bv) != 8'h00) merr = 1'b1;
        else if (clr) merr = 1'b0;
      end else begin
        mchg = 8'h00;
        if (clr) merr = 1'b0;
      end
      applyStimulus(r, e, m, av, bv, clr);
      checks++;
      if (bus.q !== mq || bus.qb !== ~mq || bus.chg !== mchg || bus.sr_err !== merr
          || bus.q !== ~bus.qb) begin
        failures++;
        nfail++;
        if (nfail <= 10)
          $display("[TB] FAIL rand_cyc%0d got q=%h qb=%h chg=%h err=%b exp q=%h qb=%h chg=%h err=%b",
                   cyc, bus.q, bus.qb, bus.chg, bus.sr_err, mq, ~mq, mchg, merr);
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.mode = FF_MODE_D; bus.a = '0; bus.b = '0; bus.err_clr = 1'b0;
    test_reset();
    test_d();
    test_t();
    test_jk();
    test_sr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
